// File: rtl/sgdma_pkg.sv
// rtl/sgdma_pkg.sv - shared header/descriptor layout and FSM encoding for ingress_sgdma
//
// Purpose: single home for the packet header field offsets, the crossbar
// descriptor layout, the null next-pointer value and the ingress FSM state
// encoding, so the DMA engine and anything decoding its descriptors agree.
//
// Header beat (low bits of the first beat of every packet):
//   [17:7] length in bytes, [6:4] priority, [3:0] destination port
// Descriptor: {length[10:0], priority[2:0], head_ptr[PTR_WIDTH-1:0]}
package sgdma_pkg;

    localparam int HDR_DEST_LSB = 0;
    localparam int HDR_DEST_W   = 4;
    localparam int HDR_PRIO_LSB = 4;
    localparam int HDR_PRIO_W   = 3;
    localparam int HDR_LEN_LSB  = 7;
    localparam int HDR_LEN_W    = 11;
    localparam int HDR_BITS     = HDR_LEN_LSB + HDR_LEN_W;

    // Metadata part of the descriptor that sits above the head pointer.
    localparam int DESC_META_W  = HDR_LEN_W + HDR_PRIO_W;

    // The null link is all ones at whatever pointer width is in use;
    // replicate this bit PTR_WIDTH times.
    localparam logic NULL_PTR_BIT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HEAD  = 3'd1,
        ST_PTR   = 3'd2,
        ST_FETCH = 3'd3,
        ST_LOAD  = 3'd4,
        ST_WRITE = 3'd5,
        ST_DESC  = 3'd6,
        ST_DROP  = 3'd7
    } sgdma_state_e;

    function automatic logic [HDR_LEN_W-1:0] hdr_len(input logic [HDR_BITS-1:0] hdr);
        return hdr[HDR_LEN_LSB +: HDR_LEN_W];
    endfunction

    function automatic logic [HDR_PRIO_W-1:0] hdr_prio(input logic [HDR_BITS-1:0] hdr);
        return hdr[HDR_PRIO_LSB +: HDR_PRIO_W];
    endfunction

    function automatic logic [HDR_DEST_W-1:0] hdr_dest(input logic [HDR_BITS-1:0] hdr);
        return hdr[HDR_DEST_LSB +: HDR_DEST_W];
    endfunction

    function automatic logic [DESC_META_W-1:0] desc_meta(input logic [HDR_LEN_W-1:0] len,
                                                         input logic [HDR_PRIO_W-1:0] prio);
        return {len, prio};
    endfunction

endpackage

// File: rtl/ingress_sgdma.sv
// rtl/ingress_sgdma.sv - scatter-gather ingress DMA: input FIFO -> linked MMU units -> crossbar descriptor
//
// Purpose: pops one packet at a time from the input FIFO, stores each payload
// beat into a free MMU unit taken from the free-pointer list, links the units
// into a chain terminated by the null pointer, then pushes a descriptor to the
// destination crossbar buffer. Packets with an invalid destination or zero
// length are popped and discarded without touching pointers, MMU or crossbar.
//
// Ports:
//   i_clk, i_rst                    clock, synchronous active-high reset
//   o_fifo_rd_en / i_fifo_dat / i_fifo_empty   input FIFO (data valid the cycle after pop)
//   o_fp_rd_en / i_fp_ptr / i_fp_empty         free-pointer list (pointer valid the cycle after pop)
//   o_mmu_wr_req / i_mmu_wr_ready / o_mmu_wr_addr / o_mmu_wr_next / o_mmu_wr_dat  unit write
//   o_cb_wr_en / o_cb_din / i_cb_full          per-port descriptor push
//   o_pkt_cnt / o_drop_cnt          saturating statistics, only with INGRESS_SGDMA_STATS_EN defined
module ingress_sgdma
    import sgdma_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int PORT_NUM   = 4,
    parameter int PTR_WIDTH  = 10
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    output logic                            o_fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]           i_fifo_dat,
    input  logic                            i_fifo_empty,
    output logic                            o_fp_rd_en,
    input  logic [PTR_WIDTH-1:0]            i_fp_ptr,
    input  logic                            i_fp_empty,
    output logic                            o_mmu_wr_req,
    input  logic                            i_mmu_wr_ready,
    output logic [PTR_WIDTH-1:0]            o_mmu_wr_addr,
    output logic [PTR_WIDTH-1:0]            o_mmu_wr_next,
    output logic [DATA_WIDTH-1:0]           o_mmu_wr_dat,
    output logic [PORT_NUM-1:0]             o_cb_wr_en,
    output logic [DESC_META_W+PTR_WIDTH-1:0] o_cb_din,
    input  logic [PORT_NUM-1:0]             i_cb_full
`ifdef INGRESS_SGDMA_STATS_EN
    ,
    output logic [31:0]                     o_pkt_cnt,
    output logic [31:0]                     o_drop_cnt
`endif
);

    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam logic [PTR_WIDTH-1:0] NULL_PTR = {PTR_WIDTH{NULL_PTR_BIT}};

    sgdma_state_e state_q, state_d;

    logic                   head_wait_q;
    logic [HDR_LEN_W-1:0]   len_q;
    logic [HDR_PRIO_W-1:0]  prio_q;
    logic [HDR_DEST_W-1:0]  dest_q;
    logic [HDR_LEN_W-1:0]   units_q;
    logic [PTR_WIDTH-1:0]   cur_ptr_q;
    logic [PTR_WIDTH-1:0]   head_ptr_q;
    logic [PTR_WIDTH-1:0]   next_q;
    logic [DATA_WIDTH-1:0]  dat_q;
    logic                   req_q;

    // The header is only on i_fifo_dat during the first HEAD cycle; if HEAD
    // has to wait for a free pointer, the latched copy is used from then on.
    logic [HDR_BITS-1:0]    hdr_raw;
    logic [HDR_LEN_W-1:0]   hdr_len_w;
    logic [HDR_PRIO_W-1:0]  hdr_prio_w;
    logic [HDR_DEST_W-1:0]  hdr_dest_w;
    logic [HDR_LEN_W:0]     len_round;
    logic [HDR_LEN_W-1:0]   hdr_units_w;
    logic                   hdr_drop_w;

    assign hdr_raw    = i_fifo_dat[HDR_BITS-1:0];
    assign hdr_len_w  = head_wait_q ? len_q  : hdr_len(hdr_raw);
    assign hdr_prio_w = head_wait_q ? prio_q : hdr_prio(hdr_raw);
    assign hdr_dest_w = head_wait_q ? dest_q : hdr_dest(hdr_raw);

    // ceil(len / BEAT_BYTES): one spare bit keeps len + BEAT_BYTES-1 from wrapping.
    assign len_round   = {1'b0, hdr_len_w} + (HDR_LEN_W + 1)'(BEAT_BYTES - 1);
    assign hdr_units_w = HDR_LEN_W'(len_round >> BEAT_SHIFT);
    assign hdr_drop_w  = ({28'd0, hdr_dest_w} >= 32'(PORT_NUM)) || (hdr_len_w == '0);

    logic                   last_unit;
    logic                   fetch_go;
    logic                   drop_pop;
    logic [PORT_NUM-1:0]    cb_sel;
    logic                   cb_full_sel;

    assign last_unit   = (units_q == HDR_LEN_W'(1));
    // The final unit links to null, so it needs no free pointer.
    assign fetch_go    = !i_fifo_empty && (last_unit || !i_fp_empty);
    assign drop_pop    = (units_q != '0) && !i_fifo_empty;
    assign cb_sel      = PORT_NUM'(1) << dest_q;
    assign cb_full_sel = |(i_cb_full & cb_sel);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (!i_fifo_empty) state_d = ST_HEAD;
            ST_HEAD: begin
                if (hdr_drop_w)       state_d = ST_DROP;
                else if (!i_fp_empty) state_d = ST_PTR;
            end
            ST_PTR:   state_d = ST_FETCH;
            ST_FETCH: if (fetch_go) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_WRITE;
            ST_WRITE: if (i_mmu_wr_ready) state_d = last_unit ? ST_DESC : ST_FETCH;
            ST_DESC:  if (!cb_full_sel) state_d = ST_IDLE;
            ST_DROP:  if (units_q == '0) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Pop/push strobes; held low while reset is asserted so nothing is
    // consumed in the cycle the reset is being sampled.
    always_comb begin
        o_fifo_rd_en = 1'b0;
        o_fp_rd_en   = 1'b0;
        o_cb_wr_en   = '0;
        if (!i_rst) begin
            unique case (state_q)
                ST_IDLE:  o_fifo_rd_en = !i_fifo_empty;
                ST_HEAD:  o_fp_rd_en   = !hdr_drop_w && !i_fp_empty;
                ST_FETCH: begin
                    o_fifo_rd_en = fetch_go;
                    o_fp_rd_en   = fetch_go && !last_unit;
                end
                ST_DESC:  o_cb_wr_en   = cb_full_sel ? '0 : cb_sel;
                ST_DROP:  o_fifo_rd_en = drop_pop;
                default: begin
                    o_fifo_rd_en = 1'b0;
                    o_fp_rd_en   = 1'b0;
                    o_cb_wr_en   = '0;
                end
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head_wait_q <= 1'b0;
            len_q       <= '0;
            prio_q      <= '0;
            dest_q      <= '0;
            units_q     <= '0;
            cur_ptr_q   <= '0;
            head_ptr_q  <= '0;
            next_q      <= '0;
            dat_q       <= '0;
            req_q       <= 1'b0;
        end else begin
            head_wait_q <= (state_q == ST_HEAD) && (state_d == ST_HEAD);
            unique case (state_q)
                ST_HEAD: begin
                    len_q   <= hdr_len_w;
                    prio_q  <= hdr_prio_w;
                    dest_q  <= hdr_dest_w;
                    units_q <= hdr_units_w;
                end
                ST_PTR: begin
                    cur_ptr_q  <= i_fp_ptr;
                    head_ptr_q <= i_fp_ptr;
                end
                ST_LOAD: begin
                    dat_q  <= i_fifo_dat;
                    next_q <= last_unit ? NULL_PTR : i_fp_ptr;
                    req_q  <= 1'b1;
                end
                ST_WRITE: begin
                    if (i_mmu_wr_ready) begin
                        req_q     <= 1'b0;
                        cur_ptr_q <= next_q;
                        units_q   <= units_q - HDR_LEN_W'(1);
                    end
                end
                ST_DROP: begin
                    if (drop_pop) units_q <= units_q - HDR_LEN_W'(1);
                end
                default: begin
                    req_q <= req_q;
                end
            endcase
        end
    end

    assign o_mmu_wr_req  = req_q;
    assign o_mmu_wr_addr = cur_ptr_q;
    assign o_mmu_wr_next = next_q;
    assign o_mmu_wr_dat  = dat_q;
    assign o_cb_din      = {desc_meta(len_q, prio_q), head_ptr_q};

`ifdef INGRESS_SGDMA_STATS_EN
    logic [31:0] pkt_cnt_q;
    logic [31:0] drop_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if ((|o_cb_wr_en) && (pkt_cnt_q != '1)) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
            if ((state_q == ST_HEAD) && (state_d == ST_DROP) && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + 32'd1;
            end
        end
    end

    assign o_pkt_cnt  = pkt_cnt_q;
    assign o_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_ingress_sgdma.sv
// tb/tb_ingress_sgdma.sv - self-checking bench for ingress_sgdma
module tb_ingress_sgdma;

    localparam int DW = 64;
    localparam int PN = 4;
    localparam int PW = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic            o_fifo_rd_en;
    logic [DW-1:0]   i_fifo_dat;
    logic            i_fifo_empty;
    logic            o_fp_rd_en;
    logic [PW-1:0]   i_fp_ptr;
    logic            i_fp_empty;
    logic            o_mmu_wr_req;
    logic            i_mmu_wr_ready;
    logic [PW-1:0]   o_mmu_wr_addr;
    logic [PW-1:0]   o_mmu_wr_next;
    logic [DW-1:0]   o_mmu_wr_dat;
    logic [PN-1:0]   o_cb_wr_en;
    logic [23:0]     o_cb_din;
    logic [PN-1:0]   i_cb_full;
`ifdef INGRESS_SGDMA_STATS_EN
    logic [31:0]     o_pkt_cnt;
    logic [31:0]     o_drop_cnt;
`endif

    always #5 clk = ~clk;

    ingress_sgdma #(.DATA_WIDTH(DW), .PORT_NUM(PN), .PTR_WIDTH(PW)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .o_fifo_rd_en   (o_fifo_rd_en),
        .i_fifo_dat     (i_fifo_dat),
        .i_fifo_empty   (i_fifo_empty),
        .o_fp_rd_en     (o_fp_rd_en),
        .i_fp_ptr       (i_fp_ptr),
        .i_fp_empty     (i_fp_empty),
        .o_mmu_wr_req   (o_mmu_wr_req),
        .i_mmu_wr_ready (i_mmu_wr_ready),
        .o_mmu_wr_addr  (o_mmu_wr_addr),
        .o_mmu_wr_next  (o_mmu_wr_next),
        .o_mmu_wr_dat   (o_mmu_wr_dat),
        .o_cb_wr_en     (o_cb_wr_en),
        .o_cb_din       (o_cb_din),
        .i_cb_full      (i_cb_full)
`ifdef INGRESS_SGDMA_STATS_EN
        ,
        .o_pkt_cnt      (o_pkt_cnt),
        .o_drop_cnt     (o_drop_cnt)
`endif
    );

    typedef struct {
        logic [PW-1:0] addr;
        logic [PW-1:0] nxt;
        logic [DW-1:0] dat;
    } mmu_wr_t;

    typedef struct {
        int            port;
        logic [PN-1:0] en;
        logic [23:0]   din;
    } cb_push_t;

    typedef struct {
        logic [10:0] len;
        logic [2:0]  prio;
        logic [3:0]  dest;
        int          units;
        bit          drop;
    } vec_t;

    // Upstream / downstream models
    logic [DW-1:0] fifo_q[$];
    logic [PW-1:0] fp_q[$];
    mmu_wr_t       got_mmu[$];
    cb_push_t      got_cb[$];
    int            fifo_pops;
    int            fp_pops;

    bit            rand_mode = 1'b0;
    bit            mmu_block = 1'b0;
    bit            fp_block  = 1'b0;
    logic [PN-1:0] cb_block  = '0;

    int errors = 0;
    int checks = 0;

    // Expected packet in flight
    logic [DW-1:0] exp_beats[$];
    logic [PW-1:0] exp_ptrs[$];
    int            cur_units;
    bit            cur_drop;
    logic [10:0]   cur_len;
    logic [2:0]    cur_prio;
    logic [3:0]    cur_dest;
    int            fresh_ptr = 16;
`ifdef INGRESS_SGDMA_STATS_EN
    logic [31:0]   drop_cnt_before;
`endif

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Responder and monitor: samples DUT outputs on the falling edge, updates
    // DUT inputs just after the rising edge.
    initial begin
        bit            pop_f;
        bit            pop_p;
        bit            prev_stall;
        bit            prev_hs;
        logic [PW-1:0] prev_addr;
        logic [PW-1:0] prev_next;
        logic [DW-1:0] prev_dat;
        int            port;
        prev_stall = 1'b0;
        prev_hs    = 1'b0;
        prev_addr  = '0;
        prev_next  = '0;
        prev_dat   = '0;
        i_fifo_dat = '0;
        i_fifo_empty = 1'b1;
        i_fp_ptr = '0;
        i_fp_empty = 1'b1;
        i_mmu_wr_ready = 1'b0;
        i_cb_full = '0;
        forever begin
            @(negedge clk);
            pop_f = o_fifo_rd_en;
            pop_p = o_fp_rd_en;
            if (pop_f) check("fifo_pop_on_empty", 128'(i_fifo_empty), 128'(0));
            if (pop_p) check("fp_pop_on_empty", 128'(i_fp_empty), 128'(0));
            if (prev_stall)
                check("mmu_hold", 128'({o_mmu_wr_req, o_mmu_wr_addr, o_mmu_wr_next, o_mmu_wr_dat}),
                      128'({1'b1, prev_addr, prev_next, prev_dat}));
            if (prev_hs) check("mmu_req_release", 128'(o_mmu_wr_req), 128'(0));
            if (o_mmu_wr_req && !i_mmu_wr_ready)
                check("pop_during_stall", 128'({pop_f, pop_p}), 128'(0));
            if (o_mmu_wr_req && i_mmu_wr_ready)
                got_mmu.push_back('{addr: o_mmu_wr_addr, nxt: o_mmu_wr_next, dat: o_mmu_wr_dat});
            if (o_cb_wr_en != '0) begin
                check("cb_onehot", 128'($onehot(o_cb_wr_en)), 128'(1));
                port = -1;
                for (int k = 0; k < PN; k++) if (o_cb_wr_en[k]) port = k;
                got_cb.push_back('{port: port, en: o_cb_wr_en, din: o_cb_din});
            end
            prev_stall = !rst && o_mmu_wr_req && !i_mmu_wr_ready;
            prev_hs    = !rst && o_mmu_wr_req && i_mmu_wr_ready;
            prev_addr  = o_mmu_wr_addr;
            prev_next  = o_mmu_wr_next;
            prev_dat   = o_mmu_wr_dat;

            @(posedge clk);
            #1;
            if (pop_f) begin
                fifo_pops++;
                if (fifo_q.size() > 0) i_fifo_dat = fifo_q.pop_front();
            end
            if (pop_p) begin
                fp_pops++;
                if (fp_q.size() > 0) i_fp_ptr = fp_q.pop_front();
            end
            i_fifo_empty   = (fifo_q.size() == 0) || (rand_mode && ($urandom_range(0, 3) == 0));
            i_fp_empty     = (fp_q.size() == 0) || fp_block || (rand_mode && ($urandom_range(0, 3) == 0));
            i_mmu_wr_ready = !mmu_block && (!rand_mode || ($urandom_range(0, 3) != 0));
            i_cb_full      = cb_block | (rand_mode ? (PN'($urandom) & PN'($urandom)) : '0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic start_pkt(input logic [10:0] len, input logic [2:0] prio, input logic [3:0] dest,
                             input int units, input bit drop);
        logic [DW-1:0] b;
        cur_len = len; cur_prio = prio; cur_dest = dest;
        cur_units = units; cur_drop = drop;
        while (!drop && fp_q.size() < units) begin
            fp_q.push_back(PW'(fresh_ptr));
            fresh_ptr = (fresh_ptr >= 1000) ? 16 : fresh_ptr + 1;
        end
        exp_ptrs.delete();
        exp_beats.delete();
        if (!drop) for (int i = 0; i < units; i++) exp_ptrs.push_back(fp_q[i]);
        fifo_pops = 0;
        fp_pops = 0;
        got_mmu.delete();
        got_cb.delete();
`ifdef INGRESS_SGDMA_STATS_EN
        drop_cnt_before = o_drop_cnt;
`endif
        b = {$urandom, $urandom};
        b[17:0] = {len, prio, dest};
        fifo_q.push_back(b);
        for (int i = 0; i < units; i++) begin
            b = {$urandom, $urandom};
            exp_beats.push_back(b);
            fifo_q.push_back(b);
        end
    endtask

    task automatic finish_pkt();
        bit done;
        int budget;
        logic [PW-1:0] enext;
        done = 1'b0;
        budget = 200 + 40 * cur_units;
        for (int c = 0; c < budget && !done; c++) begin
            tick();
            done = cur_drop ? (fifo_pops >= cur_units + 1) : (got_cb.size() > 0);
        end
        check("pkt_done", 128'(done), 128'(1));
        repeat (4) tick();
        check("fifo_pops", 128'(fifo_pops), 128'(cur_units + 1));
        check("fp_pops", 128'(fp_pops), 128'(cur_drop ? 0 : cur_units));
        check("mmu_writes", 128'(got_mmu.size()), 128'(cur_drop ? 0 : cur_units));
        check("cb_pushes", 128'(got_cb.size()), 128'(cur_drop ? 0 : 1));
        if (!cur_drop) begin
            for (int i = 0; i < cur_units && i < got_mmu.size(); i++) begin
                enext = (i == cur_units - 1) ? 10'h3FF : exp_ptrs[i + 1];
                check("mmu_wr", 128'({got_mmu[i].addr, got_mmu[i].nxt, got_mmu[i].dat}),
                      128'({exp_ptrs[i], enext, exp_beats[i]}));
            end
            if (got_cb.size() > 0)
                check("cb_desc", 128'({got_cb[0].en, got_cb[0].din}),
                      128'({PN'(1) << cur_dest, cur_len, cur_prio, exp_ptrs[0]}));
        end
`ifdef INGRESS_SGDMA_STATS_EN
        if (cur_drop) check("drop_cnt", 128'(o_drop_cnt), 128'(drop_cnt_before + 32'd1));
`endif
    endtask

    task automatic run_pkt(input logic [10:0] len, input logic [2:0] prio, input logic [3:0] dest,
                           input int units, input bit drop);
        start_pkt(len, prio, dest, units, drop);
        finish_pkt();
    endtask

    task automatic wait_req(input string name);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            tick();
            seen = o_mmu_wr_req;
        end
        check(name, 128'(seen), 128'(1));
    endtask

    function automatic logic [114:0] all_outs();
        return {o_fifo_rd_en, o_fp_rd_en, o_mmu_wr_req, o_mmu_wr_addr, o_mmu_wr_next,
                o_mmu_wr_dat, o_cb_wr_en, o_cb_din};
    endfunction

    vec_t vecs[8];

    initial begin
        int snap_f;
        int snap_p;
        bit ok;
        logic [10:0] rl;
        logic [3:0]  rd;
        int          ru;

        rst = 1'b1;
        repeat (3) tick();
        check("reset_outputs", 128'(all_outs()), 128'(0));
        rst = 1'b0;
        tick();

        // Two-unit packet into preset pointers 5, 9
        fp_q.delete();
        fp_q.push_back(10'd5);
        fp_q.push_back(10'd9);
        run_pkt(11'd16, 3'd3, 4'd2, 2, 1'b0);
        if (got_mmu.size() >= 2) begin
            check("r26_w0", 128'({got_mmu[0].addr, got_mmu[0].nxt}), 128'({10'd5, 10'd9}));
            check("r26_w1", 128'({got_mmu[1].addr, got_mmu[1].nxt}), 128'({10'd9, 10'h3FF}));
        end
        if (got_cb.size() >= 1)
            check("r26_cb", 128'({got_cb[0].en, got_cb[0].din}), 128'({4'b0100, 11'd16, 3'd3, 10'd5}));

        // Table: len, prio, dest, expected units, expected drop
        vecs[0] = '{len: 11'd17,   prio: 3'd1, dest: 4'd1,  units: 3,   drop: 1'b0};
        vecs[1] = '{len: 11'd24,   prio: 3'd2, dest: 4'd7,  units: 3,   drop: 1'b1};
        vecs[2] = '{len: 11'd0,    prio: 3'd0, dest: 4'd1,  units: 0,   drop: 1'b1};
        vecs[3] = '{len: 11'd1,    prio: 3'd7, dest: 4'd0,  units: 1,   drop: 1'b0};
        vecs[4] = '{len: 11'd8,    prio: 3'd5, dest: 4'd3,  units: 1,   drop: 1'b0};
        vecs[5] = '{len: 11'd9,    prio: 3'd4, dest: 4'd4,  units: 2,   drop: 1'b1};
        vecs[6] = '{len: 11'd2047, prio: 3'd6, dest: 4'd2,  units: 256, drop: 1'b0};
        vecs[7] = '{len: 11'd64,   prio: 3'd3, dest: 4'd15, units: 8,   drop: 1'b1};
        for (int v = 0; v < 8; v++)
            run_pkt(vecs[v].len, vecs[v].prio, vecs[v].dest, vecs[v].units, vecs[v].drop);

        // MMU not ready for 5 cycles: write held, nothing popped
        mmu_block = 1'b1;
        start_pkt(11'd20, 3'd2, 4'd1, 3, 1'b0);
        wait_req("stall_req_seen");
        snap_f = fifo_pops;
        snap_p = fp_pops;
        repeat (5) tick();
        check("stall_no_pops", 128'({32'(fifo_pops), 32'(fp_pops)}), 128'({32'(snap_f), 32'(snap_p)}));
        mmu_block = 1'b0;
        finish_pkt();

        // Crossbar port 2 full for 10 cycles at descriptor time
        cb_block = 4'b0100;
        start_pkt(11'd24, 3'd1, 4'd2, 3, 1'b0);
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            tick();
            ok = (got_mmu.size() == 3);
        end
        check("cbfull_writes_done", 128'(ok), 128'(1));
        repeat (10) tick();
        check("cbfull_no_push", 128'(got_cb.size()), 128'(0));
        cb_block = '0;
        finish_pkt();

        // Free list empty while fetching: stall without pops
        start_pkt(11'd24, 3'd4, 4'd1, 3, 1'b0);
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            tick();
            ok = (fp_pops >= 1);
        end
        check("fpstall_head_ptr", 128'(ok), 128'(1));
        fp_block = 1'b1;
        repeat (10) tick();
        check("fpstall_no_pops", 128'({32'(fifo_pops), 32'(fp_pops)}), 128'({32'd1, 32'd1}));
        fp_block = 1'b0;
        finish_pkt();

        // Reset while in WRITE, then a normal packet
        mmu_block = 1'b1;
        start_pkt(11'd16, 3'd5, 4'd0, 2, 1'b0);
        wait_req("rst_req_seen");
        tick();
        rst = 1'b1;
        fifo_q.delete();
        fp_q.delete();
        tick();
        check("rst_in_write_outputs", 128'(all_outs()), 128'(0));
        rst = 1'b0;
        mmu_block = 1'b0;
        tick();
        check("rst_idle_outputs", 128'(all_outs()), 128'(0));
        run_pkt(11'd16, 3'd6, 4'd3, 2, 1'b0);

        // Randomized packets against the arithmetic reference model
        rand_mode = 1'b1;
        for (int n = 0; n < 40; n++) begin
            rl = 11'($urandom_range(0, 120));
            rd = 4'($urandom_range(0, 5));
            ru = (int'(rl) + 7) / 8;
            run_pkt(rl, 3'($urandom), rd, ru, (rd >= 4) || (rl == 0));
        end
        rand_mode = 1'b0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
